dmem_byte_ctrl: RTL and testbench

DMEM_BYTE_CTRL -- requirements
Module: dmem_byte_ctrl

---
 rtl/dmem_byte_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_dmem_byte_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_byte_ctrl.sv
// Byte-addressable 32-bit data memory with RISC-V load/store sizing and a post-reset clear sweep.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into faults.
module dmem_byte_ctrl #(
  parameter int ADDR_W       = 12,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_idx_reg, clr_idx_next;
  logic              clearing;

  logic              accept;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_off;
  logic              size_ok;
  logic              misalign;
  logic              fault;
  logic              store_go;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;

  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic [31:0]       rd_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;

  logic              rsp_valid_reg;
  logic              rsp_fault_reg;
  logic [31:0]       rsp_rdata_reg;

  // Address bits above the memory are deliberately ignored (aliasing).
  logic              unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= CLEAR_ON_RST ? ST_CLEAR : ST_READY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CLEAR: if (clr_idx_reg == {ADDR_W{1'b1}}) state_next = ST_READY;
      ST_READY: state_next = ST_READY;
      default:  state_next = ST_READY;
    endcase
  end

  // req_ready is held low while rst is high even when no sweep is configured.
  always_comb begin
    busy      = (state_reg == ST_CLEAR);
    req_ready = (state_reg == ST_READY) && !rst;
    clearing  = (state_reg == ST_CLEAR);
  end

  // ---------------- clear sweep counter ----------------
  always_comb begin
    clr_idx_next = clearing ? clr_idx_reg + ADDR_W'(1) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_idx_reg <= '0;
    end else begin
      clr_idx_reg <= clr_idx_next;
    end
  end

  // ---------------- request decode ----------------
  assign accept   = req_valid && req_ready;
  assign word_idx = req_addr[ADDR_W+1:2];
  assign byte_off = req_addr[1:0];

  always_comb begin
    case (req_size)
      3'b000, 3'b001, 3'b010: size_ok = 1'b1;
      3'b100, 3'b101:         size_ok = !req_we;
      default:                size_ok = 1'b0;
    endcase
  end

  always_comb begin
`ifdef DMEM_MISALIGN_TRAP_EN
    case (req_size[1:0])
      2'b01:   misalign = byte_off[0];
      2'b10:   misalign = (byte_off != 2'b00);
      default: misalign = 1'b0;
    endcase
`else
    misalign = 1'b0;
`endif
  end

  assign fault    = !size_ok || misalign;
  assign store_go = accept && req_we && !fault;

  // Store data is replicated across lanes so each lane just picks its own byte.
  always_comb begin
    lane_be    = 4'b0000;
    lane_wdata = req_wdata;
    case (req_size[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << byte_off;
        lane_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_be    = byte_off[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        lane_be    = 4'b1111;
        lane_wdata = req_wdata;
      end
      default: begin
        lane_be    = 4'b0000;
        lane_wdata = req_wdata;
      end
    endcase
  end

  // ---------------- byte-lane storage ----------------
  assign mem_waddr = clearing ? clr_idx_reg : word_idx;
  assign mem_wdata = clearing ? 32'h0 : lane_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [0:DEPTH-1];

      assign mem_we[gi] = clearing || (store_go && lane_be[gi]);

      always_ff @(posedge clk) begin
        if (mem_we[gi]) begin
          lane_mem[mem_waddr] <= mem_wdata[gi*8 +: 8];
        end
      end

      // Sampled into the response register at the same edge as any write,
      // so a load sees the pre-write contents.
      assign rd_word[gi*8 +: 8] = lane_mem[word_idx];
    end
  endgenerate

  // ---------------- load extraction and extension ----------------
  always_comb begin
    case (byte_off)
      2'b00:   byte_sel = rd_word[7:0];
      2'b01:   byte_sel = rd_word[15:8];
      2'b10:   byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    case (req_size)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'h0, byte_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = 32'h0;
    endcase
  end

  // ---------------- registered response ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_fault_reg <= 1'b0;
      rsp_rdata_reg <= 32'h0;
    end else begin
      rsp_valid_reg <= accept;
      rsp_fault_reg <= accept && fault;
      rsp_rdata_reg <= (accept && !req_we && !fault) ? load_data : 32'h0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_fault = rsp_fault_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_dmem_byte_ctrl.sv
// Randomised bench for dmem_byte_ctrl (ADDR_W=4) against a word-array model, plus literal checks.
module tb_dmem_byte_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_size = 3'b000;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        busy;

  dmem_byte_ctrl #(.ADDR_W(AW), .CLEAR_ON_RST(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_fault (rsp_fault),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mdl [DEPTH];
  logic        exp_valid = 1'b0;
  logic        exp_fault = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_ready = 1'b0;
  int          sweep_left = 0;

  logic        last_valid;
  logic        last_fault;
  logic [31:0] last_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Outputs settle after the posedge; compare on the falling edge.
  always @(negedge clk) begin
    check("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_valid});
    check("rsp_fault", {31'h0, rsp_fault}, {31'h0, exp_fault});
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("req_ready", {31'h0, req_ready}, {31'h0, exp_ready});
    check("busy", {31'h0, busy}, {31'h0, !exp_ready});
  end

  // Response to a request against the current model contents.
  function automatic void model_access(input logic we, input logic [31:0] addr,
                                       input logic [2:0] size,
                                       output logic flt, output logic [31:0] rd);
    int          idx;
    int          off;
    logic        legal;
    logic        mis;
    logic [31:0] w, b, h;
    idx = int'((addr / 4) % DEPTH);
    off = int'(addr % 4);
    if (we) legal = (size <= 3'd2);
    else    legal = (size == 3'd0 || size == 3'd1 || size == 3'd2 || size == 3'd4 || size == 3'd5);
    mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((size % 4) == 1 && (off % 2) != 0) mis = 1'b1;
    if ((size % 4) == 2 && off != 0)       mis = 1'b1;
`endif
    flt = !legal || mis;
    rd  = 32'h0;
    if (!flt && !we) begin
      w = mdl[idx];
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * (off / 2))) & 32'hFFFF;
      case (size)
        3'd0: rd = (b >= 128) ? (b | 32'hFFFFFF00) : b;
        3'd1: rd = (h >= 32768) ? (h | 32'hFFFF0000) : h;
        3'd2: rd = w;
        3'd4: rd = b;
        3'd5: rd = h;
        default: rd = 32'h0;
      endcase
    end
  endfunction

  function automatic void model_store(input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [2:0] size);
    int          idx;
    int          off;
    logic [31:0] w;
    logic [7:0]  v;
    idx = int'((addr / 4) % DEPTH);
    off = int'(addr % 4);
    w = mdl[idx];
    for (int k = 0; k < 4; k++) begin
      v = 8'h0;
      if (size == 3'd0 && k == off) begin
        v = wdata[7:0];
        w[k*8 +: 8] = v;
      end else if (size == 3'd1 && (k / 2) == (off / 2)) begin
        v = wdata[(k % 2)*8 +: 8];
        w[k*8 +: 8] = v;
      end else if (size == 3'd2) begin
        v = wdata[k*8 +: 8];
        w[k*8 +: 8] = v;
      end
    end
    mdl[idx] = w;
  endfunction

  // One clock of stimulus; entered and left just after a posedge.
  task automatic do_req(input logic v, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] sz);
    logic        acc;
    logic        f;
    logic [31:0] r;
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_size  = sz;
    acc = v && exp_ready;
    model_access(we, a, sz, f, r);
    @(posedge clk);
    #1;
    exp_valid = acc;
    exp_fault = acc && f;
    exp_rdata = (acc && !we && !f) ? r : 32'h0;
    if (acc && we && !f) model_store(a, wd, sz);
    if (!exp_ready && sweep_left > 0) begin
      sweep_left--;
      if (sweep_left == 0) begin
        exp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
      end
    end
    last_valid = rsp_valid;
    last_fault = rsp_fault;
    last_rdata = rsp_rdata;
    req_valid  = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst        = 1'b1;
    req_valid  = 1'b0;
    exp_valid  = 1'b0;
    exp_fault  = 1'b0;
    exp_rdata  = 32'h0;
    exp_ready  = 1'b0;
    sweep_left = 0;
    repeat (cycles) @(posedge clk);
    #1;
    rst        = 1'b0;
    sweep_left = DEPTH;
  endtask

  task automatic rand_req();
    do_req($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom,
           $urandom, 3'($urandom_range(0, 7)));
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    do_reset(3);
    check("busy_after_rst", {31'h0, busy}, 32'h1);

    // Abort the sweep at index 7, then time the full restart.
    repeat (7) do_req(1'b1, 1'b0, $urandom, 32'h0, 3'd2);
    do_reset(2);
    n = 0;
    while (!req_ready && n < 40) begin
      do_req(1'b1, 1'b0, $urandom, 32'h0, 3'd2);
      n++;
    end
    check("ready_latency", n, DEPTH);

    for (int i = 0; i < DEPTH; i++) begin
      do_req(1'b1, 1'b0, i * 4, 32'h0, 3'd2);
      check("lw_zero", last_rdata, 32'h0);
    end

    do_req(1'b1, 1'b1, 32'h10, 32'h80FF7F01, 3'd2);
    do_req(1'b1, 1'b0, 32'h11, 32'h0, 3'd0);
    check("lb_0x11", last_rdata, 32'h0000007F);
    do_req(1'b1, 1'b0, 32'h13, 32'h0, 3'd4);
    check("lbu_0x13", last_rdata, 32'h00000080);

    do_req(1'b1, 1'b1, 32'h20, 32'h11223344, 3'd2);
    check("sw_valid", {31'h0, last_valid}, 32'h1);
    do_req(1'b1, 1'b1, 32'h22, 32'h000000AA, 3'd0);
    check("sb_valid", {31'h0, last_valid}, 32'h1);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 3'd2);
    check("lw_merge", last_rdata, 32'h11AA3344);

    do_req(1'b1, 1'b0, 32'h21, 32'h0, 3'd1);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("lh_mis_fault", {31'h0, last_fault}, 32'h1);
    check("lh_mis_rdata", last_rdata, 32'h0);
`else
    check("lh_mis_fault", {31'h0, last_fault}, 32'h0);
    check("lh_mis_rdata", last_rdata, 32'h00003344);
`endif

    do_req(1'b1, 1'b0, 32'h20, 32'h0, 3'd3);
    check("size3_fault", {31'h0, last_fault}, 32'h1);
    check("size3_rdata", last_rdata, 32'h0);
    do_req(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 3'd2);
    do_req(1'b1, 1'b0, 32'h00, 32'h0, 3'd2);
    check("alias_lw", last_rdata, 32'hCAFEF00D);
    do_req(1'b1, 1'b1, 32'h04, 32'h12345678, 3'd6);
    check("st_ill_fault", {31'h0, last_fault}, 32'h1);
    do_req(1'b1, 1'b0, 32'h04, 32'h0, 3'd2);
    check("st_ill_nowrite", last_rdata, 32'h0);

    repeat (400) rand_req();

    // Reset on top of an in-flight response, then keep going.
    do_req(1'b1, 1'b0, 32'h0, 32'h0, 3'd2);
    do_reset(1);
    repeat (DEPTH + 200) rand_req();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
